// File: rtl/switch_word_input_pkg.sv
// Shared widths and press-detector state encoding
// for the switch word input path.
package switch_word_input_pkg;

  localparam int WORD_W          = 24;
  localparam int DIGIT_W         = 6;
  localparam int DIGITS_PER_WORD = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } press_state_t;

endpackage

// File: rtl/switch_word_input_debouncer.sv
// Two-flop synchroniser plus one shared debounce
// counter for a vector of raw board inputs.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int WIDTH           = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Counter survives changes among differing values; it only
      // restarts once s2 falls back to the accepted level.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_word_input.sv
// Operator input path: debounced LOAD presses shift switch
// digits into a word handed to the CPU via Valid/Ack.
module switch_word_input
  import switch_word_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DIGIT_W-1:0] switch,
  input  logic              load,
  input  logic              ack,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  output logic [WORD_W-1:0] preview,
  output logic [1:0]        digits,
  output logic              overrun
);

  logic [DIGIT_W:0]  stable_vec;
  logic              stable_load;
  logic [DIGIT_W-1:0] stable_sw;
  press_state_t      state;
  logic              press;
  logic              word_done;
  logic [WORD_W-1:0] shifted;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .WIDTH          (DIGIT_W + 1)
  ) u_deb (
    .clock (clock),
    .reset (reset),
    .raw   ({load, switch}),
    .stable(stable_vec)
  );

  assign stable_load = stable_vec[DIGIT_W];
  assign stable_sw   = stable_vec[DIGIT_W-1:0];

  assign press     = (state == IDLE) && stable_load;
  assign word_done = press &&
                     (digits == 2'(DIGITS_PER_WORD - 1));
  assign shifted   = {preview[WORD_W-DIGIT_W-1:0], stable_sw};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      data    <= '0;
      valid   <= 1'b0;
      preview <= '0;
      digits  <= '0;
      overrun <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): if (stable_load)  state <= HELD;
        (state == HELD): if (!stable_load) state <= IDLE;
        default:         state <= IDLE;
      endcase

      if (valid && ack) valid <= 1'b0;

      if (press) begin
        if (word_done) begin
          digits  <= '0;
          preview <= '0;
          // An Ack in this cycle frees the slot for the new word.
          if (!valid || ack) begin
            data  <= shifted;
            valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          digits  <= digits + 2'd1;
          preview <= shifted;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_word_input.sv
// Directed, table-driven bench for switch_word_input
// with a short debounce window.
module tb_switch_word_input;

  logic        clock;
  logic        reset;
  logic [5:0]  switch;
  logic        load;
  logic        ack;
  logic [23:0] data;
  logic        valid;
  logic [23:0] preview;
  logic [1:0]  digits;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  switch_word_input #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .switch (switch),
    .load   (load),
    .ack    (ack),
    .data   (data),
    .valid  (valid),
    .preview(preview),
    .digits (digits),
    .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  sw;
    logic [1:0]  exp_digits;
    logic [23:0] exp_preview;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(string name, logic [23:0] act,
                     logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(logic [5:0] sw);
    switch = sw;
    step(8);
    load = 1'b1;
    step(8);
    load = 1'b0;
    step(8);
  endtask

  initial begin
    vecs[0] = '{6'h3F, 2'd1, 24'h00003F, 1'b0};
    vecs[1] = '{6'h00, 2'd2, 24'h000FC0, 1'b0};
    vecs[2] = '{6'h2A, 2'd3, 24'h03F02A, 1'b0};
    vecs[3] = '{6'h15, 2'd0, 24'h000000, 1'b1};

    reset  = 1'b0;
    switch = '0;
    load   = 1'b0;
    ack    = 1'b0;
    step(2);
    chk("rst_data", data, 24'h0);
    chk("rst_valid", 24'(valid), 24'h0);
    chk("rst_preview", preview, 24'h0);
    chk("rst_digits", 24'(digits), 24'h0);
    chk("rst_overrun", 24'(overrun), 24'h0);
    reset = 1'b1;
    step(2);

    // Basic word assembly
    for (int i = 0; i < 4; i++) begin
      press(vecs[i].sw);
      chk($sformatf("tbl%0d_digits", i), 24'(digits),
          24'(vecs[i].exp_digits));
      chk($sformatf("tbl%0d_preview", i), preview,
          vecs[i].exp_preview);
      chk($sformatf("tbl%0d_valid", i), 24'(valid),
          24'(vecs[i].exp_valid));
    end
    chk("word1_data", data, 24'hFC0A95);

    // Second word with no Ack: overrun
    press(6'h01);
    press(6'h02);
    press(6'h03);
    press(6'h04);
    chk("ovr_flag", 24'(overrun), 24'h1);
    chk("ovr_data", data, 24'hFC0A95);
    chk("ovr_valid", 24'(valid), 24'h1);
    chk("ovr_digits", 24'(digits), 24'h0);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("ack_valid", 24'(valid), 24'h0);
    chk("ack_overrun", 24'(overrun), 24'h1);
    chk("ack_data", data, 24'hFC0A95);

    // Idle Ack and switch movement
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    switch = 6'h2A;
    step(10);
    chk("idle_valid", 24'(valid), 24'h0);
    chk("idle_digits", 24'(digits), 24'h0);
    chk("idle_preview", preview, 24'h0);
    chk("idle_data", data, 24'hFC0A95);
    chk("idle_stable", 24'(dut.stable_vec), 24'h2A);

    // Bouncing LOAD then long hold
    for (int i = 0; i < 5; i++) begin
      load = 1'b1;
      step(1);
      load = 1'b0;
      step(1);
    end
    step(2);
    chk("bounce_digits", 24'(digits), 24'h0);
    load = 1'b1;
    step(10);
    chk("hold_digits", 24'(digits), 24'h1);
    step(100);
    chk("long_hold_digits", 24'(digits), 24'h1);
    load = 1'b0;
    step(8);
    chk("release_digits", 24'(digits), 24'h1);
    chk("release_preview", preview, 24'h00002A);

    // Reset mid-word, no clock edge needed
    press(6'h11);
    chk("pre_rst_digits", 24'(digits), 24'h2);
    chk("pre_rst_preview", preview, 24'h000A91);
    #2;
    reset = 1'b0;
    #1;
    chk("async_data", data, 24'h0);
    chk("async_valid", 24'(valid), 24'h0);
    chk("async_preview", preview, 24'h0);
    chk("async_digits", 24'(digits), 24'h0);
    chk("async_overrun", 24'(overrun), 24'h0);
    step(3);
    reset = 1'b1;
    step(2);

    // Fresh word with exact latency on the final press
    press(6'h05);
    press(6'h0A);
    press(6'h14);
    switch = 6'h3C;
    step(8);
    load = 1'b1;
    step(6);
    chk("lat_before", 24'(valid), 24'h0);
    step(1);
    chk("lat_valid", 24'(valid), 24'h1);
    chk("lat_data", data, 24'h14A53C);
    chk("lat_digits", 24'(digits), 24'h0);
    chk("lat_overrun", 24'(overrun), 24'h0);
    load = 1'b0;
    step(8);

    // Ack coincident with word completion
    press(6'h01);
    press(6'h02);
    press(6'h03);
    switch = 6'h04;
    step(8);
    load = 1'b1;
    step(6);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("same_valid", 24'(valid), 24'h1);
    chk("same_data", data, 24'h0420C4);
    chk("same_overrun", 24'(overrun), 24'h0);
    load = 1'b0;
    step(8);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
